// File: rtl/morse_tx_sequencer.sv
// rtl/morse_tx_sequencer.sv - queued Morse character to timed on/off keying sequencer
//
// Purpose: buffers host-written Morse codes in a small FIFO and plays them out
// on o_tone_out with ITU unit timing (dot 1U, dash 3U, element gap 1U,
// character gap 3U, word space 4U on top of the preceding character gap).
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset
//   i_char_valid   host offers i_char_code this cycle
//   i_char_code    [8:6] element count L (0 = word space, 7 illegal), [5:0] pattern, bit0 first, 1 = dash
//   o_char_ready   FIFO not full (forced high while abort is held)
//   i_abort        flush-and-stop request
//   o_tone_out     keying output, 1 = light on
//   o_busy         sequencer active or characters queued
//   o_char_done    one-cycle pulse on the last cycle of a character or space
//   o_fifo_level   number of queued characters
//   o_err_len      sticky: an L=7 code was offered

module morse_tx_sequencer #(
  parameter int UNIT_CYCLES = 12500000,
  parameter int CNT_W       = 26,
  parameter int FIFO_AW     = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_char_valid,
  input  logic [8:0]       i_char_code,
  output logic             o_char_ready,
  input  logic             i_abort,
  output logic             o_tone_out,
  output logic             o_busy,
  output logic             o_char_done,
  output logic [FIFO_AW:0] o_fifo_level,
  output logic             o_err_len
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [CNT_W-1:0] C_1U = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_3U = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_4U = CNT_W'(4 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ELEM,
    S_EGAP,
    S_CGAP,
    S_WGAP
  } state_t;

  logic [8:0]       r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_shift;
  logic [2:0]       r_remain;
  logic             r_tone;
  logic             r_done;
  logic             r_err;

  logic [FIFO_AW:0] w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_store;
  logic             w_pop;
  logic [8:0]       w_head;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == (FIFO_AW + 1)'(DEPTH));
  assign w_empty = (w_level == '0);
  assign w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  // An L=7 code completes the handshake but is never stored.
  assign w_push  = i_char_valid && !w_full && !i_abort;
  assign w_store = w_push && (i_char_code[8:6] != 3'd7);
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !i_abort;

  assign o_char_ready = !w_full || i_abort;
  assign o_busy       = (r_state != S_IDLE) || !w_empty;
  assign o_fifo_level = w_level;
  assign o_tone_out   = r_tone;
  assign o_char_done  = r_done;
  assign o_err_len    = r_err;

  function automatic logic [CNT_W-1:0] elem_len(input logic dash);
    return dash ? C_3U : C_1U;
  endfunction

  always_ff @(posedge i_clk) begin
    if (w_store && !i_reset) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_char_code;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_remain <= '0;
      r_tone   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else if (i_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tone   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + (FIFO_AW + 1)'(1);
      if (w_push && (i_char_code[8:6] == 3'd7)) r_err <= 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + (FIFO_AW + 1)'(1);
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift  <= w_head[5:0];
            r_remain <= w_head[8:6];
            if (w_head[8:6] == 3'd0) begin
              r_state <= S_WGAP;
              r_cnt   <= C_4U;
            end else begin
              r_state <= S_ELEM;
              r_cnt   <= elem_len(w_head[0]);
              r_tone  <= 1'b1;
            end
          end
        end

        S_ELEM: begin
          if (r_cnt == '0) begin
            r_tone <= 1'b0;
            if (r_remain > 3'd1) begin
              r_state  <= S_EGAP;
              r_cnt    <= C_1U;
              r_remain <= r_remain - 3'd1;
            end else begin
              r_state <= S_CGAP;
              r_cnt   <= C_3U;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_EGAP: begin
          if (r_cnt == '0) begin
            // Next element is bit1 of the pattern before the shift lands.
            r_shift <= r_shift >> 1;
            r_state <= S_ELEM;
            r_cnt   <= elem_len(r_shift[1]);
            r_tone  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_CGAP, S_WGAP: begin
          // Registered pulse: raise it one count early so it lands on the last gap cycle.
          if (r_cnt == CNT_W'(1)) r_done <= 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// tb/tb_morse_tx_sequencer.sv - self-checking bench for morse_tx_sequencer
module tb_morse_tx_sequencer;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_valid;
  logic [8:0] char_code;
  logic       char_ready;
  logic       abort;
  logic       tone_out;
  logic       busy;
  logic       char_done;
  logic [2:0] fifo_level;
  logic       err_len;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int run_len = 0;
  bit discard = 1'b0;
  int exp_q[$];

  always #5 clk = ~clk;

  morse_tx_sequencer #(.UNIT_CYCLES(U), .CNT_W(5), .FIFO_AW(2)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_char_valid (char_valid),
    .i_char_code  (char_code),
    .o_char_ready (char_ready),
    .i_abort      (abort),
    .o_tone_out   (tone_out),
    .o_busy       (busy),
    .o_char_done  (char_done),
    .o_fifo_level (fifo_level),
    .o_err_len    (err_len)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every completed tone pulse is compared with the next expected length.
  always @(negedge clk) begin
    if (char_done) done_cnt++;
    if (tone_out) begin
      run_len++;
    end else if (run_len != 0) begin
      if (discard) begin
        discard = 1'b0;
      end else if (exp_q.size() == 0) begin
        check("pulse_unexpected", run_len, 0);
      end else begin
        check("pulse_len", run_len, exp_q.pop_front());
      end
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_pulses(input logic [8:0] code);
    logic [2:0] l;
    l = code[8:6];
    for (int i = 0; i < int'(l); i++) exp_q.push_back(code[i] ? 3 * U : U);
  endtask

  task automatic push(input logic [8:0] code, input bit exp_ready);
    char_valid = 1'b1;
    char_code  = code;
    check("ready_before_push", int'(char_ready), int'(exp_ready));
    tick();
    char_valid = 1'b0;
    if (exp_ready) add_pulses(code);
  endtask

  task automatic wait_tone(input bit level, input string tag);
    int n = 0;
    while (tone_out !== level && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, n, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check({tag, "_timeout"}, n, 0);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tone"},  int'(tone_out),   0);
    check({tag, "_done"},  int'(char_done),  0);
    check({tag, "_err"},   int'(err_len),    0);
    check({tag, "_level"}, int'(fifo_level), 0);
    check({tag, "_ready"}, int'(char_ready), 1);
    check({tag, "_busy"},  int'(busy),       0);
  endtask

  localparam logic [8:0] C_E  = 9'b001_000000;
  localparam logic [8:0] C_T  = 9'b001_000001;
  localparam logic [8:0] C_A  = 9'b010_000010;
  localparam logic [8:0] C_SP = 9'b000_000000;
  localparam logic [8:0] C_BAD = 9'b111_000000;

  initial begin
    int d0;
    int n;
    reset = 1'b1;
    char_valid = 1'b0;
    char_code = '0;
    abort = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_vals("rst");

    // 1: single dot
    d0 = done_cnt;
    push(C_E, 1'b1);
    check("e_level_push", int'(fifo_level), 1);
    check("e_tone_before_pop", int'(tone_out), 0);
    tick();
    check("e_tone_after_pop", int'(tone_out), 1);
    check("e_level_pop", int'(fifo_level), 0);
    wait_tone(1'b0, "e_fall");
    n = 1;
    while (char_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("e_cgap_done_cycle", n, 3 * U);
    tick();
    check("e_busy_after", int'(busy), 0);
    check("e_done_count", done_cnt - d0, 1);

    // 2: dot then dash, bits above L set to prove they are ignored
    d0 = done_cnt;
    push(C_A | 9'b000_111100, 1'b1);
    check("a_level_push", int'(fifo_level), 1);
    tick();
    check("a_level_pop", int'(fifo_level), 0);
    wait_idle("a_idle");
    check("a_done_count", done_cnt - d0, 1);
    check("a_sb_empty", exp_q.size(), 0);

    // 3: E, word space, E
    d0 = done_cnt;
    push(C_E, 1'b1);
    push(C_SP, 1'b1);
    push(C_E, 1'b1);
    wait_tone(1'b1, "sp_rise1");
    wait_tone(1'b0, "sp_fall1");
    n = 0;
    while (tone_out !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("sp_low_gap", n, 3 * U + 1 + 4 * U + 1);
    wait_idle("sp_idle");
    check("sp_done_count", done_cnt - d0, 3);

    // 4: fill FIFO while a dash plays
    d0 = done_cnt;
    push(C_T, 1'b1);
    wait_tone(1'b1, "full_rise");
    for (int i = 0; i < 4; i++) begin
      push(C_E, 1'b1);
      check("full_level", int'(fifo_level), i + 1);
    end
    push(C_A, 1'b0);
    check("full_level_after5", int'(fifo_level), 4);
    wait_idle("full_idle");
    check("full_done_count", done_cnt - d0, 5);
    check("full_sb_empty", exp_q.size(), 0);

    // 5: illegal length
    d0 = done_cnt;
    push(C_BAD, 1'b1);
    exp_q.delete();
    check("bad_err", int'(err_len), 1);
    check("bad_level", int'(fifo_level), 0);
    repeat (3) tick();
    check("bad_err_sticky", int'(err_len), 1);
    push(C_E, 1'b1);
    wait_idle("bad_idle");
    check("bad_e_done", done_cnt - d0, 1);
    check("bad_err_still", int'(err_len), 1);

    // 6a: abort mid-dash with two queued
    d0 = done_cnt;
    push(C_T, 1'b1);
    wait_tone(1'b1, "ab_rise");
    push(C_E, 1'b1);
    push(C_E, 1'b1);
    check("ab_level_pre", int'(fifo_level), 2);
    discard = 1'b1;
    abort = 1'b1;
    char_valid = 1'b1;
    char_code = C_E;
    check("ab_ready_held", int'(char_ready), 1);
    tick();
    abort = 1'b0;
    char_valid = 1'b0;
    exp_q.delete();
    check("ab_tone", int'(tone_out), 0);
    check("ab_level", int'(fifo_level), 0);
    check("ab_busy", int'(busy), 0);
    check("ab_err", int'(err_len), 0);
    repeat (20) tick();
    check("ab_no_done", done_cnt - d0, 0);
    check("ab_tone_quiet", int'(tone_out), 0);

    // 6b: same with reset, err_len set beforehand
    push(C_BAD, 1'b1);
    exp_q.delete();
    push(C_T, 1'b1);
    wait_tone(1'b1, "rs_rise");
    push(C_E, 1'b1);
    d0 = done_cnt;
    discard = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check_reset_vals("mid_rst");
    repeat (20) tick();
    check("rs_no_done", done_cnt - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
